// File: rtl/sdram_bist.sv
// Self-test initiator for the SDRAM controller buffer port: fills the buffer with an
// address pattern, burst-writes each 256-word block, reads it back and checks it.
module sdram_bist #(
    parameter int unsigned AW   = 24,
    parameter int unsigned NB_W = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [AW-1:0]   BASE,
    input  logic [NB_W-1:0] NUM_BLOCKS,
    input  logic            INVERT,
    output logic [7:0]      ADDR,
    output logic [31:0]     WD,
    output logic            WE,
    output logic            WE_A,
    output logic            WE_LEN,
    input  logic [31:0]     RD,
    input  logic            BUSY,
    output logic            RUNNING,
    output logic            DONE,
    output logic            FAIL,
    output logic [15:0]     ERR_CNT,
    output logic [AW-1:0]   ERR_ADDR
);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_WA, S_WL, S_WW, S_RA, S_RL, S_RW, S_CHK, S_FIN
    } state_t;

    localparam logic [AW-1:0] BLK_STEP = AW'(256);
    localparam logic [31:0]   CMD_WR   = {1'b1, 23'b0, 8'hFF};
    localparam logic [31:0]   CMD_RD   = {1'b0, 23'b0, 8'hFF};

    state_t          state_q;
    logic [AW-1:0]   base_q;
    logic [NB_W-1:0] nb_q;
    logic            inv_q;
    logic [NB_W-1:0] blk_q;
    logic [AW-1:0]   blk_addr_q;
    logic            guard_q;
    logic [8:0]      cnt_q;
    logic [7:0]      rd_idx_q;
    logic [7:0]      addr_q;
    logic [31:0]     wd_q;
    logic            we_q;
    logic            we_a_q;
    logic            we_len_q;
    logic            running_q;
    logic            done_q;
    logic            fail_q;
    logic [15:0]     err_cnt_q;
    logic [AW-1:0]   err_addr_q;

    logic [AW-1:0]   blk_next_addr;
    logic [AW-1:0]   fill_next_addr;
    logic [AW-1:0]   chk_addr;
    logic            last_blk;
    logic            mismatch;

    function automatic logic [31:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [31:0] p;
        p = 32'(a);
        return inv ? ~p : p;
    endfunction

    assign blk_next_addr  = blk_addr_q + BLK_STEP;
    assign fill_next_addr = blk_addr_q + AW'({1'b0, addr_q} + 9'd1);
    assign chk_addr       = blk_addr_q + AW'(rd_idx_q);
    assign last_blk       = (blk_q == nb_q);
    // RD lags ADDR by one cycle, so the first CHK cycle carries no data
    assign mismatch       = (cnt_q != '0) && (RD != pattern(chk_addr, inv_q));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            nb_q       <= '0;
            inv_q      <= 1'b0;
            blk_q      <= '0;
            blk_addr_q <= '0;
            guard_q    <= 1'b0;
            cnt_q      <= '0;
            rd_idx_q   <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            we_a_q     <= 1'b0;
            we_len_q   <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START && !BUSY) begin
                        base_q     <= BASE;
                        nb_q       <= NUM_BLOCKS;
                        inv_q      <= INVERT;
                        blk_q      <= '0;
                        blk_addr_q <= BASE;
                        done_q     <= 1'b0;
                        fail_q     <= 1'b0;
                        err_cnt_q  <= '0;
                        err_addr_q <= '0;
                        running_q  <= 1'b1;
                        we_q       <= 1'b1;
                        addr_q     <= '0;
                        wd_q       <= pattern(BASE, INVERT);
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (addr_q == 8'hFF) begin
                        we_q    <= 1'b0;
                        we_a_q  <= 1'b1;
                        wd_q    <= 32'(blk_addr_q);
                        state_q <= S_WA;
                    end else begin
                        addr_q <= addr_q + 8'd1;
                        wd_q   <= pattern(fill_next_addr, inv_q);
                    end
                end
                S_WA: begin
                    we_a_q   <= 1'b0;
                    we_len_q <= 1'b1;
                    wd_q     <= CMD_WR;
                    state_q  <= S_WL;
                end
                S_WL: begin
                    we_len_q <= 1'b0;
                    wd_q     <= '0;
                    guard_q  <= 1'b1;
                    state_q  <= S_WW;
                end
                S_WW: begin
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!BUSY) begin
                        if (last_blk) begin
                            blk_q      <= '0;
                            blk_addr_q <= base_q;
                            we_a_q     <= 1'b1;
                            wd_q       <= 32'(base_q);
                            state_q    <= S_RA;
                        end else begin
                            blk_q      <= blk_q + NB_W'(1);
                            blk_addr_q <= blk_next_addr;
                            we_q       <= 1'b1;
                            addr_q     <= '0;
                            wd_q       <= pattern(blk_next_addr, inv_q);
                            state_q    <= S_FILL;
                        end
                    end
                end
                S_RA: begin
                    we_a_q   <= 1'b0;
                    we_len_q <= 1'b1;
                    wd_q     <= CMD_RD;
                    state_q  <= S_RL;
                end
                S_RL: begin
                    we_len_q <= 1'b0;
                    wd_q     <= '0;
                    guard_q  <= 1'b1;
                    state_q  <= S_RW;
                end
                S_RW: begin
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!BUSY) begin
                        addr_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CHK;
                    end
                end
                S_CHK: begin
                    addr_q   <= addr_q + 8'd1;
                    rd_idx_q <= addr_q;
                    cnt_q    <= cnt_q + 9'd1;
                    if (mismatch) begin
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        if (!fail_q) begin
                            fail_q     <= 1'b1;
                            err_addr_q <= chk_addr;
                        end
                    end
                    if (cnt_q == 9'd256) begin
                        if (last_blk) begin
                            state_q <= S_FIN;
                        end else begin
                            blk_q      <= blk_q + NB_W'(1);
                            blk_addr_q <= blk_next_addr;
                            we_a_q     <= 1'b1;
                            wd_q       <= 32'(blk_next_addr);
                            state_q    <= S_RA;
                        end
                    end
                end
                S_FIN: begin
                    done_q    <= 1'b1;
                    running_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ADDR     = addr_q;
    assign WD       = wd_q;
    assign WE       = we_q;
    assign WE_A     = we_a_q;
    assign WE_LEN   = we_len_q;
    assign RUNNING  = running_q;
    assign DONE     = done_q;
    assign FAIL     = fail_q;
    assign ERR_CNT  = err_cnt_q;
    assign ERR_ADDR = err_addr_q;

endmodule
